// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier, one partial product per clock.
// The accumulate adder is a two-level carry-lookahead built from 4-bit slices.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned NumSlices = WIDTH / 4;
  localparam int unsigned CntW      = $clog2(WIDTH) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]         state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]     add_x;
  logic [WIDTH-1:0]     add_y;
  logic [WIDTH-1:0]     bit_g;
  logic [WIDTH-1:0]     bit_p;
  logic [WIDTH-1:0]     bit_c;
  logic [WIDTH-1:0]     sum;
  logic [NumSlices-1:0] grp_g;
  logic [NumSlices-1:0] grp_p;
  logic [NumSlices:0]   grp_c;
  logic                 cout;
  logic [2*WIDTH-1:0]   acc_next;

  // Slice P/G feed a second-level lookahead; its carries re-enter each slice's bit lookahead.
  always_comb begin
    int unsigned base;
    logic        term;
    add_x = acc_q[2*WIDTH-1:WIDTH];
    add_y = acc_q[0] ? mcand_q : '0;
    bit_g = add_x & add_y;
    bit_p = add_x ^ add_y;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    bit_c = '0;
    term  = 1'b0;
    base  = 0;

    for (int s = 0; s < int'(NumSlices); s++) begin
      base     = 4 * s;
      grp_g[s] = bit_g[base+3]
               | (bit_p[base+3] & bit_g[base+2])
               | (bit_p[base+3] & bit_p[base+2] & bit_g[base+1])
               | (bit_p[base+3] & bit_p[base+2] & bit_p[base+1] & bit_g[base]);
      grp_p[s] = &bit_p[base+:4];
    end

    // Carry-in of the whole adder is zero, so no cin term appears in the group carries.
    for (int k = 1; k <= int'(NumSlices); k++) begin
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        grp_c[k] = grp_c[k] | term;
      end
    end

    for (int s = 0; s < int'(NumSlices); s++) begin
      base           = 4 * s;
      bit_c[base]    = grp_c[s];
      bit_c[base+1]  = bit_g[base] | (bit_p[base] & grp_c[s]);
      bit_c[base+2]  = bit_g[base+1]
                     | (bit_p[base+1] & bit_g[base])
                     | (bit_p[base+1] & bit_p[base] & grp_c[s]);
      bit_c[base+3]  = bit_g[base+2]
                     | (bit_p[base+2] & bit_g[base+1])
                     | (bit_p[base+2] & bit_p[base+1] & bit_g[base])
                     | (bit_p[base+2] & bit_p[base+1] & bit_p[base] & grp_c[s]);
    end

    sum      = bit_p ^ bit_c;
    cout     = grp_c[NumSlices];
    acc_next = {cout, sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        StRun: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            product_q <= acc_next;
            state_q   <= StDone;
          end
        end
        default: begin
          if (start) begin
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: WIDTH=32 and WIDTH=8 instances, directed
// corner cases plus random operands checked against plain integer multiplication.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, start32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  logic        rst8, start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  shift_add_multiplier #(.WIDTH(32)) u_mul32 (
    .clk(clk), .rst(rst32), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product(prod32)
  );

  shift_add_multiplier #(.WIDTH(8)) u_mul8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // inj: RUN cycle in which a competing start is driven; rcyc: RUN cycle in which rst is asserted.
  task automatic mul32(input logic [31:0] x, input logic [31:0] y, input int inj,
                       input int rcyc, input string tag);
    logic [63:0] exp;
    int n;
    exp = {32'b0, x} * {32'b0, y};
    a32 = x; b32 = y; start32 = 1'b1;
    step();
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      if (n == inj) begin start32 = 1'b1; a32 = 32'd15; b32 = 32'd9; end
      if (n == rcyc) rst32 = 1'b1;
      step();
      start32 = 1'b0; rst32 = 1'b0;
      if (n == rcyc) break;
    end
    if (rcyc > 0) begin
      check({tag, "_rst_busy"}, 64'(busy32), 64'd0);
      check({tag, "_rst_done"}, 64'(done32), 64'd0);
      check({tag, "_rst_prod"}, prod32, 64'd0);
      step();
      check({tag, "_rst_nodone"}, 64'(done32), 64'd0);
      check({tag, "_rst_idle"}, 64'(busy32), 64'd0);
    end else begin
      check({tag, "_busy_len"}, 64'(n), 64'd32);
      check({tag, "_done"}, 64'(done32), 64'd1);
      check({tag, "_prod"}, prod32, exp);
      step();
      check({tag, "_done_clr"}, 64'(done32), 64'd0);
      check({tag, "_prod_hold"}, prod32, exp);
    end
  endtask

  // Ends in the DONE cycle so the caller can chain another start or let it go idle.
  task automatic mul8(input logic [7:0] x, input logic [7:0] y, input string tag);
    logic [15:0] exp;
    int n;
    exp = {8'b0, x} * {8'b0, y};
    a8 = x; b8 = y; start8 = 1'b1;
    step();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      step();
    end
    check({tag, "_busy_len"}, 64'(n), 64'd8);
    check({tag, "_done"}, 64'(done8), 64'd1);
    check({tag, "_prod"}, 64'(prod8), 64'(exp));
  endtask

  initial begin
    int e1;
    logic [7:0] rx, ry;
    rst32 = 1'b1; start32 = 1'b0; a32 = '0; b32 = '0;
    rst8  = 1'b1; start8  = 1'b0; a8  = '0; b8  = '0;

    // Reset held two cycles, with start asserted alongside it in one of them.
    step();
    start32 = 1'b1; a32 = 32'd5; b32 = 32'd9;
    start8  = 1'b1; a8  = 8'd5;  b8  = 8'd9;
    step();
    start32 = 1'b0; start8 = 1'b0; rst32 = 1'b0; rst8 = 1'b0;
    check("reset_busy", 64'(busy32), 64'd0);
    check("reset_done", 64'(done32), 64'd0);
    check("reset_prod", prod32, 64'd0);
    check("reset_prod8", 64'(prod8), 64'd0);
    step();
    check("reset_no_run", 64'(busy32), 64'd0);
    check("reset_no_run8", 64'(busy8), 64'd0);

    mul32(32'd5, 32'd9, 0, 0, "basic");
    mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "max");
    mul32(32'd0, 32'hFFFF_FFFF, 0, 0, "zero");
    mul32(32'h8000_0000, 32'd2, 0, 0, "carry");
    mul32(32'd11, 32'd4, 5, 0, "start_busy");
    mul32(32'd15, 32'd9, 0, 10, "mid_rst");
    mul32(32'd2, 32'd3, 0, 0, "after_rst");

    for (int i = 0; i < 10; i++) mul32($urandom, $urandom, 0, 0, "rand32");

    // Back-to-back on the narrow instance: restart during the DONE cycle.
    mul8(8'd5, 8'd9, "b2b_first");
    e1 = edge_cnt;
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("b2b_no_gap", 64'(busy8), 64'd1);
    begin
      int n;
      n = 0;
      while (!done8 && n < 40) begin n++; step(); end
    end
    check("b2b_gap_edges", 64'(edge_cnt - e1), 64'd9);
    check("b2b_second_prod", 64'(prod8), 64'd65025);
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b_hold", 64'(prod8), 64'd65025);
      check("b2b_idle_done", 64'(done8), 64'd0);
    end

    for (int i = 0; i < 12; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      mul8(rx, ry, "rand8");
      if (i % 2 == 1) step();
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
